// File: rtl/tlb_csr_if.sv
// Commit-side bundle for tlb_csr_ctrl: op request handshake plus the CSR access bus.
interface tlb_csr_if;
    logic        req_vld;
    logic [2:0]  req_op;
    logic [4:0]  req_inv_op;
    logic [9:0]  req_inv_asid;
    logic [18:0] req_inv_va;
    logic        req_rdy;
    logic        op_done;
    logic        refetch_req;
    logic        csr_we;
    logic [13:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;

    modport master (
        output req_vld, req_op, req_inv_op, req_inv_asid, req_inv_va,
        output csr_we, csr_addr, csr_wdata,
        input  req_rdy, op_done, refetch_req, csr_rdata
    );

    modport slave (
        input  req_vld, req_op, req_inv_op, req_inv_asid, req_inv_va,
        input  csr_we, csr_addr, csr_wdata,
        output req_rdy, op_done, refetch_req, csr_rdata
    );
endinterface

// File: rtl/tlb_csr_ctrl.sv
// TLB CSR owner and TLB-op initiator: IDLE -> ISSUE (one strobe) -> DONE (op_done),
// with TLBSRCH/TLBRD results folded back into TLBIDX/TLBEHI/TLBELO at the end of ISSUE.
module tlb_csr_ctrl #(
    parameter int IDX_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    tlb_csr_if.slave         bus,
    output logic             tlbsrch,
    output logic             tlbrd,
    output logic             tlbwr,
    output logic             tlbfill,
    output logic             invtlb,
    output logic [IDX_W-1:0] tlb_idx,
    output logic             tlb_ne,
    output logic [5:0]       tlb_ps,
    output logic [9:0]       tlb_asid,
    output logic [18:0]      tlb_vpn,
    output logic [31:0]      tlb_elo0,
    output logic [31:0]      tlb_elo1,
    output logic [4:0]       tlb_inv_op,
    output logic [9:0]       tlb_inv_asid,
    output logic [18:0]      tlb_inv_va,
    input  logic             srch_hit,
    input  logic [IDX_W-1:0] srch_idx,
    input  logic             rd_en,
    input  logic [5:0]       rd_ps,
    input  logic [18:0]      rd_vpn,
    input  logic [19:0]      rd_ppn0,
    input  logic [19:0]      rd_ppn1,
    input  logic [5:0]       rd_flags0,
    input  logic [5:0]       rd_flags1,
    input  logic             rd_g
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DONE} state_e;

    localparam logic [2:0]  OP_SRCH = 3'd0;
    localparam logic [2:0]  OP_RD   = 3'd1;
    localparam logic [2:0]  OP_WR   = 3'd2;
    localparam logic [2:0]  OP_FILL = 3'd3;
    localparam logic [2:0]  OP_INV  = 3'd4;

    localparam logic [13:0] A_TLBIDX = 14'h10;
    localparam logic [13:0] A_TLBEHI = 14'h11;
    localparam logic [13:0] A_ELO0   = 14'h12;
    localparam logic [13:0] A_ELO1   = 14'h13;
    localparam logic [13:0] A_ASID   = 14'h18;

    // PPN[27:8], G[6], MAT/PLV/D/V[5:0]; everything else reads 0.
    localparam logic [31:0] ELO_MASK = 32'h0FFF_FF7F;

    state_e           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [4:0]       inv_op_q, inv_op_d;
    logic [9:0]       inv_asid_q, inv_asid_d;
    logic [18:0]      inv_va_q, inv_va_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             ne_q, ne_d;
    logic [5:0]       ps_q, ps_d;
    logic [18:0]      vpn_q, vpn_d;
    logic [31:0]      elo0_q, elo0_d;
    logic [31:0]      elo1_q, elo1_d;
    logic [9:0]       asid_q, asid_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            op_q       <= '0;
            inv_op_q   <= '0;
            inv_asid_q <= '0;
            inv_va_q   <= '0;
            idx_q      <= '0;
            ne_q       <= 1'b0;
            ps_q       <= '0;
            vpn_q      <= '0;
            elo0_q     <= '0;
            elo1_q     <= '0;
            asid_q     <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            inv_op_q   <= inv_op_d;
            inv_asid_q <= inv_asid_d;
            inv_va_q   <= inv_va_d;
            idx_q      <= idx_d;
            ne_q       <= ne_d;
            ps_q       <= ps_d;
            vpn_q      <= vpn_d;
            elo0_q     <= elo0_d;
            elo1_q     <= elo1_d;
            asid_q     <= asid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (bus.req_vld) state_d = S_ISSUE;
            S_ISSUE: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.req_rdy     = (state_q == S_IDLE);
        bus.op_done     = (state_q == S_DONE);
        bus.refetch_req = (state_q == S_DONE) &&
                          (op_q == OP_WR || op_q == OP_FILL || op_q == OP_INV);
        tlbsrch         = (state_q == S_ISSUE) && (op_q == OP_SRCH);
        tlbrd           = (state_q == S_ISSUE) && (op_q == OP_RD);
        tlbwr           = (state_q == S_ISSUE) && (op_q == OP_WR);
        tlbfill         = (state_q == S_ISSUE) && (op_q == OP_FILL);
        invtlb          = (state_q == S_ISSUE) && (op_q == OP_INV);
    end

    // CSR writes only land in IDLE, so a write beside req_vld is visible to the ISSUE that follows.
    always_comb begin
        op_d       = op_q;
        inv_op_d   = inv_op_q;
        inv_asid_d = inv_asid_q;
        inv_va_d   = inv_va_q;
        idx_d      = idx_q;
        ne_d       = ne_q;
        ps_d       = ps_q;
        vpn_d      = vpn_q;
        elo0_d     = elo0_q;
        elo1_d     = elo1_q;
        asid_d     = asid_q;
        if (state_q == S_IDLE) begin
            if (bus.req_vld) begin
                op_d       = bus.req_op;
                inv_op_d   = bus.req_inv_op;
                inv_asid_d = bus.req_inv_asid;
                inv_va_d   = bus.req_inv_va;
            end
            if (bus.csr_we) begin
                case (bus.csr_addr)
                    A_TLBIDX: begin
                        idx_d = bus.csr_wdata[IDX_W-1:0];
                        ps_d  = bus.csr_wdata[29:24];
                        ne_d  = bus.csr_wdata[31];
                    end
                    A_TLBEHI: vpn_d  = bus.csr_wdata[31:13];
                    A_ELO0:   elo0_d = bus.csr_wdata & ELO_MASK;
                    A_ELO1:   elo1_d = bus.csr_wdata & ELO_MASK;
                    A_ASID:   asid_d = bus.csr_wdata[9:0];
                    default: ;
                endcase
            end
        end else if (state_q == S_ISSUE) begin
            case (op_q)
                OP_SRCH: begin
                    ne_d = !srch_hit;
                    if (srch_hit) idx_d = srch_idx;
                end
                OP_RD: begin
                    ne_d = !rd_en;
                    if (rd_en) begin
                        ps_d   = rd_ps;
                        vpn_d  = rd_vpn;
                        elo0_d = {4'b0, rd_ppn0, 1'b0, rd_g, rd_flags0};
                        elo1_d = {4'b0, rd_ppn1, 1'b0, rd_g, rd_flags1};
                    end else begin
                        ps_d   = '0;
                        vpn_d  = '0;
                        elo0_d = '0;
                        elo1_d = '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.csr_rdata = '0;
        case (bus.csr_addr)
            A_TLBIDX: bus.csr_rdata = {ne_q, 1'b0, ps_q, {(24-IDX_W){1'b0}}, idx_q};
            A_TLBEHI: bus.csr_rdata = {vpn_q, 13'b0};
            A_ELO0:   bus.csr_rdata = elo0_q;
            A_ELO1:   bus.csr_rdata = elo1_q;
            A_ASID:   bus.csr_rdata = {22'b0, asid_q};
            default:  bus.csr_rdata = '0;
        endcase
    end

    // ELOs go out raw; the TLB forms the entry G bit as elo0.G & elo1.G.
    assign tlb_idx      = idx_q;
    assign tlb_ne       = ne_q;
    assign tlb_ps       = ps_q;
    assign tlb_asid     = asid_q;
    assign tlb_vpn      = vpn_q;
    assign tlb_elo0     = elo0_q;
    assign tlb_elo1     = elo1_q;
    assign tlb_inv_op   = inv_op_q;
    assign tlb_inv_asid = inv_asid_q;
    assign tlb_inv_va   = inv_va_q;

endmodule
